// File: rtl/l2_pkg.sv
// l2_pkg: op encodings, beat geometry and line types shared with the L2 data store.
package l2_pkg;
  typedef enum logic [1:0] {OP_RD = 2'd0, OP_RDX = 2'd1, OP_WR = 2'd2, OP_ATOM = 2'd3} l2_op_e;
  localparam int L2_BEATS  = 8;
  localparam int L2_BEAT_W = 64;
  localparam int L2_LINE_W = L2_BEATS * L2_BEAT_W;
  typedef logic [25:0] l2_addr_t;
  typedef logic [L2_LINE_W-1:0] l2_line_t;
endpackage

// File: rtl/l2resp_linebuf.sv
// l2resp_linebuf: two-entry line storage, per-word writes into the fill entry, read mux on head.
module l2resp_linebuf
  import l2_pkg::*;
(
  input  logic           clk,
  input  logic           wr_en_i,
  input  logic           wr_ptr_i,
  input  logic [2:0]     wr_idx_i,
  input  logic [63:0]    wr_data_i,
  input  logic           first_i,
  input  logic [1:0]     wr_op_i,
  input  l2_addr_t       wr_addr_i,
  input  logic           wr_err_i,
  input  logic           rd_ptr_i,
  output logic [1:0]     rd_op_o,
  output l2_addr_t       rd_addr_o,
  output l2_line_t       rd_data_o,
  output logic           rd_err_o
);
  l2_line_t   data_q [2];
  logic [1:0] op_q   [2];
  l2_addr_t   addr_q [2];
  logic [1:0] err_q;
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_ptr_i][{3'd0, wr_idx_i}*L2_BEAT_W +: L2_BEAT_W] <= wr_data_i;
      err_q[wr_ptr_i] <= (~first_i & err_q[wr_ptr_i]) | wr_err_i;
      if (first_i) begin
        op_q[wr_ptr_i]   <= wr_op_i;
        addr_q[wr_ptr_i] <= wr_addr_i;
      end
    end
  end
  assign rd_op_o   = op_q[rd_ptr_i];
  assign rd_addr_o = addr_q[rd_ptr_i];
  assign rd_data_o = data_q[rd_ptr_i];
  assign rd_err_o  = err_q[rd_ptr_i];
endmodule

// File: rtl/l2resp_asm.sv
// l2resp_asm: assembles 8-beat L2 responses into 512-bit lines behind a two-entry buffer.
// Optional L2RESP_CHECK_EN checks op/addr stability across a burst and drives proto_err.
module l2resp_asm
  import l2_pkg::*;
#(
  parameter int NUM_ENTRIES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        l2_resp_valid,
  input  logic        l2_resp_error,
  input  logic [1:0]  l2_resp_op,
  input  logic [25:0] l2_resp_addr,
  input  logic [63:0] l2_resp_rdata,
  output logic        resp_ready,
  output logic        line_valid,
  output logic [1:0]  line_op,
  output logic [25:0] line_addr,
  output logic [511:0] line_data,
  output logic        line_error,
  input  logic        line_ready,
  output logic        proto_err
);
  logic [2:0] beat_q, beat_d;
  logic [1:0] cnt_q, cnt_d;
  logic       wp_q, wp_d, rp_q, rp_d;
  logic       acc, first, last, pop, mism, head_err;
  assign resp_ready = (cnt_q != 2'd2);
  assign line_valid = (cnt_q != 2'd0);
  assign acc   = l2_resp_valid & resp_ready;
  assign first = (beat_q == 3'd0);
  assign last  = acc & (beat_q == 3'd7);
  assign pop   = line_valid & line_ready;
  always_comb begin
    beat_d = acc ? beat_q + 3'd1 : beat_q;
    wp_d   = wp_q ^ last;
    rp_d   = rp_q ^ pop;
    cnt_d  = cnt_q + {1'b0, last} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      cnt_q  <= '0;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
    end else begin
      beat_q <= beat_d;
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
    end
  end
`ifdef L2RESP_CHECK_EN
  logic [1:0] hdr_op_q;
  l2_addr_t   hdr_addr_q;
  logic       proto_err_q;
  assign mism = acc & ~first & ((l2_resp_op != hdr_op_q) | (l2_resp_addr != hdr_addr_q));
  always_ff @(posedge clk) begin
    if (acc & first) begin
      hdr_op_q   <= l2_resp_op;
      hdr_addr_q <= l2_resp_addr;
    end
    proto_err_q <= rst ? 1'b0 : (proto_err_q | mism);
  end
  assign proto_err = proto_err_q;
`else
  assign mism      = 1'b0;
  assign proto_err = 1'b0;
`endif
  l2resp_linebuf u_buf (
    .clk       (clk),
    .wr_en_i   (acc),
    .wr_ptr_i  (wp_q),
    .wr_idx_i  (beat_q),
    .wr_data_i (l2_resp_rdata),
    .first_i   (first),
    .wr_op_i   (l2_resp_op),
    .wr_addr_i (l2_resp_addr),
    .wr_err_i  (l2_resp_error | mism),
    .rd_ptr_i  (rp_q),
    .rd_op_o   (line_op),
    .rd_addr_o (line_addr),
    .rd_data_o (line_data),
    .rd_err_o  (head_err)
  );
  assign line_error = head_err;
endmodule

// File: tb/tb_l2resp_asm.sv
// tb_l2resp_asm: scoreboard bench for l2resp_asm; expected lines queued at issue, checked on pop.
module tb_l2resp_asm;
  typedef struct packed {
    logic [1:0]   op;
    logic [25:0]  addr;
    logic [511:0] data;
    logic         err;
  } line_t;

  logic         clk = 1'b0, rst = 1'b1;
  logic         l2_resp_valid = 1'b0, l2_resp_error = 1'b0;
  logic [1:0]   l2_resp_op = '0;
  logic [25:0]  l2_resp_addr = '0;
  logic [63:0]  l2_resp_rdata = '0;
  logic         resp_ready, line_valid, line_error, line_ready = 1'b0, proto_err;
  logic [1:0]   line_op;
  logic [25:0]  line_addr;
  logic [511:0] line_data;

  int checks = 0, errors = 0, got = 0;
  line_t exp_q[$];

  always #5 clk = ~clk;

  l2resp_asm #(.NUM_ENTRIES(2)) dut (
    .clk(clk), .rst(rst), .l2_resp_valid(l2_resp_valid), .l2_resp_error(l2_resp_error),
    .l2_resp_op(l2_resp_op), .l2_resp_addr(l2_resp_addr), .l2_resp_rdata(l2_resp_rdata),
    .resp_ready(resp_ready), .line_valid(line_valid), .line_op(line_op), .line_addr(line_addr),
    .line_data(line_data), .line_error(line_error), .line_ready(line_ready), .proto_err(proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && line_valid && line_ready) begin
      line_t e;
      got++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_line: got addr %0h with no expected line", line_addr);
      end else begin
        e = exp_q.pop_front();
        if (line_op !== e.op || line_addr !== e.addr || line_data !== e.data || line_error !== e.err) begin
          errors++;
          $display("FAIL line_%0d: got op %0h addr %0h err %0b w0 %0h w7 %0h expected op %0h addr %0h err %0b w0 %0h w7 %0h",
                   got, line_op, line_addr, line_error, line_data[63:0], line_data[511:448],
                   e.op, e.addr, e.err, e.data[63:0], e.data[511:448]);
        end
      end
    end
  end

  function automatic line_t mk(input logic [1:0] op, input logic [25:0] addr, input logic [63:0] base, input logic err);
    line_t l;
    l.op = op; l.addr = addr; l.err = err;
    for (int i = 0; i < 8; i++) l.data[i*64 +: 64] = base | 64'(i);
    return l;
  endfunction

  task automatic beat(input logic [1:0] op, input logic [25:0] addr, input logic [63:0] d, input logic err);
    int t = 0;
    l2_resp_valid = 1'b1; l2_resp_op = op; l2_resp_addr = addr; l2_resp_rdata = d; l2_resp_error = err;
    @(negedge clk);
    while (!resp_ready && t < 200) begin @(negedge clk); t++; end
    if (!resp_ready) begin
      checks++; errors++;
      $display("FAIL beat_timeout: resp_ready stuck at 0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    l2_resp_valid = 1'b0; l2_resp_error = 1'b0;
  endtask

  // Sends beats [0, nb); errbeat marks one faulty beat, beats >= chg use a perturbed address.
  task automatic send(input logic [1:0] op, input logic [25:0] addr, input logic [63:0] base,
                      input int nb, input int errbeat, input int chg);
    for (int i = 0; i < nb; i++)
      beat(op, (i >= chg) ? addr ^ 26'h1 : addr, base | 64'(i), i == errbeat);
  endtask

  task automatic drain();
    int t = 0;
    line_ready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_line_valid", 64'(line_valid), 64'd0);
    chk("rst_resp_ready", 64'(resp_ready), 64'd1);
    chk("rst_proto_err", 64'(proto_err), 64'd0);

    // Single line: valid exactly one cycle after beat 7
    @(posedge clk); #1;
    line_ready = 1'b1;
    exp_q.push_back(mk(2'd0, 26'h0000123, 64'h1111_0000_0000_0000, 1'b0));
    send(2'd0, 26'h0000123, 64'h1111_0000_0000_0000, 8, -1, 99);
    @(negedge clk);
    chk("single_valid_n1", 64'(line_valid), 64'd1);
    @(negedge clk);
    chk("single_valid_n2", 64'(line_valid), 64'd0);
    chk("single_got", 64'(got), 64'd1);

    // Backpressure: two lines fill the buffer, third stalls at beat 0
    @(posedge clk); #1;
    line_ready = 1'b0;
    exp_q.push_back(mk(2'd1, 26'h0000200, 64'h2222_0000_0000_0000, 1'b0));
    exp_q.push_back(mk(2'd2, 26'h0000201, 64'h3333_0000_0000_0000, 1'b0));
    exp_q.push_back(mk(2'd3, 26'h0000202, 64'h4444_0000_0000_0000, 1'b0));
    send(2'd1, 26'h0000200, 64'h2222_0000_0000_0000, 8, -1, 99);
    send(2'd2, 26'h0000201, 64'h3333_0000_0000_0000, 8, -1, 99);
    @(negedge clk);
    chk("bp_ready_low", 64'(resp_ready), 64'd0);
    chk("bp_head_addr", 64'(line_addr), 64'h200);
    @(posedge clk); #1;
    fork
      send(2'd3, 26'h0000202, 64'h4444_0000_0000_0000, 8, -1, 99);
    join_none
    repeat (3) @(negedge clk);
    chk("bp_ready_stall", 64'(resp_ready), 64'd0);
    chk("bp_head_hold", 64'(line_data[127:64]), 64'h2222_0000_0000_0001);
    @(posedge clk); #1;
    line_ready = 1'b1;
    @(posedge clk); #1;
    line_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_restore", 64'(resp_ready), 64'd1);
    chk("bp_head_next", 64'(line_addr), 64'h201);
    wait fork;
    drain();

    // Error on beat 3 of line A only
    exp_q.push_back(mk(2'd0, 26'h0000300, 64'h5555_0000_0000_0000, 1'b1));
    exp_q.push_back(mk(2'd0, 26'h0000301, 64'h6666_0000_0000_0000, 1'b0));
    send(2'd0, 26'h0000300, 64'h5555_0000_0000_0000, 8, 3, 99);
    send(2'd0, 26'h0000301, 64'h6666_0000_0000_0000, 8, -1, 99);
    drain();

    // Simultaneous beat-7 completion and pop with one line buffered
    @(posedge clk); #1;
    line_ready = 1'b0;
    exp_q.push_back(mk(2'd1, 26'h0000400, 64'h7777_0000_0000_0000, 1'b0));
    exp_q.push_back(mk(2'd2, 26'h0000401, 64'h8888_0000_0000_0000, 1'b0));
    send(2'd1, 26'h0000400, 64'h7777_0000_0000_0000, 8, -1, 99);
    send(2'd2, 26'h0000401, 64'h8888_0000_0000_0000, 7, -1, 99);
    line_ready = 1'b1;
    beat(2'd2, 26'h0000401, 64'h8888_0000_0000_0007, 1'b0);
    line_ready = 1'b0;
    @(negedge clk);
    chk("sim_valid", 64'(line_valid), 64'd1);
    chk("sim_ready", 64'(resp_ready), 64'd1);
    chk("sim_head_addr", 64'(line_addr), 64'h401);
    chk("sim_got", 64'(got), 64'd7);
    drain();

    // Reset after beat 4 discards the partial line
    send(2'd3, 26'h0000500, 64'h9999_0000_0000_0000, 5, -1, 99);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(line_valid), 64'd0);
    chk("mid_rst_ready", 64'(resp_ready), 64'd1);
    @(posedge clk); #1;
    exp_q.push_back(mk(2'd1, 26'h0000600, 64'hAAAA_0000_0000_0000, 1'b0));
    send(2'd1, 26'h0000600, 64'hAAAA_0000_0000_0000, 8, -1, 99);
    drain();
    chk("mid_rst_got", 64'(got), 64'd9);

    // Address change on beat 5: flagged only when the checker is compiled in
`ifdef L2RESP_CHECK_EN
    exp_q.push_back(mk(2'd0, 26'h0000700, 64'hBBBB_0000_0000_0000, 1'b1));
    send(2'd0, 26'h0000700, 64'hBBBB_0000_0000_0000, 8, -1, 5);
    drain();
    repeat (3) @(negedge clk);
    chk("chk_proto_sticky", 64'(proto_err), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("chk_proto_cleared", 64'(proto_err), 64'd0);
`else
    exp_q.push_back(mk(2'd0, 26'h0000700, 64'hBBBB_0000_0000_0000, 1'b0));
    send(2'd0, 26'h0000700, 64'hBBBB_0000_0000_0000, 8, -1, 5);
    drain();
    repeat (3) @(negedge clk);
    chk("nochk_proto", 64'(proto_err), 64'd0);
`endif
    chk("total_lines", 64'(got), 64'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2resp_asm.md
# l2resp_asm

Line-assembly stage directly downstream of the L2 data store's response port. It collects the 8 consecutive 64-bit beats of each L2 read response into a 512-bit line. Completed lines are held in a two-entry buffer and presented to the L1 refill path on a single valid/ready handshake. This decouples the L1 from the beat-level stall of the L2 data pipeline.

## Interface
Parameters:
- NUM_ENTRIES, 2, completed-line buffer depth; only the value 2 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- l2_resp_valid  in  1  a response beat is valid.
- l2_resp_error  in  1  per-beat error flag.
- l2_resp_op  in  2  request op; constant across a burst.
- l2_resp_addr  in  26  line address [31:6]; constant across a burst.
- l2_resp_rdata  in  64  beat data.
- resp_ready  out  1  beat accepted when valid & ready.
- line_valid  out  1  completed line available.
- line_op  out  2  op of the head line.
- line_addr  out  26  address [31:6] of the head line.
- line_data  out  512  line data; word i is bits [64i+63:64i].
- line_error  out  1  OR of all beat errors, plus checker error when compiled in.
- line_ready  in  1  consumer takes the head line when line_valid & line_ready.
- proto_err  out  1  sticky protocol-violation flag; tied 0 without the macro.

## Operation
- Every response is exactly 8 beats. Beat n carries line word n, so the word index equals a 3-bit beat counter starting at 0.
- Assembly:
  - On each accepted beat, rdata is written to word[beat] of the fill entry, and error is ORed into that entry's error bit.
  - On beat 0, op and addr are captured and the entry's error bit is cleared before ORing.
  - On beat 7, the fill entry is marked complete, the fill pointer toggles, and the beat counter wraps to 0.
- Buffer: two entries with fill pointer wp, head pointer rp and complete count cnt (0..2).
  - resp_ready = (cnt != 2).
  - The entry under assembly is never counted in cnt.
- Output: line_valid = (cnt != 0). line_* are driven from entry rp. A pop advances rp and decrements cnt.
- Simultaneous beat-7 completion and pop: cnt is unchanged, both pointers advance, and no data is lost.
- Beats outside a valid & ready handshake have no effect.

## Timing
- Reset values:
  - line_valid=0, resp_ready=1, proto_err=0.
  - cnt=0, wp=0, rp=0, beat counter=0.
  - line_* data: don't-care.
- Reset mid-burst discards the partial line. The next accepted beat is treated as beat 0.
- Latency: beat 7 accepted in cycle N gives line_valid=1 in cycle N+1 (registered).
- resp_ready depends only on registered cnt. There is no combinational path from line_ready to resp_ready.
  - A pop in cycle N raises resp_ready in cycle N+1.
- With cnt=2, resp_ready=0. A mid-burst beat stall of any length is legal and preserves the partial fill.
- line_* hold steady while line_valid=1 and line_ready=0.

## Configuration
- L2RESP_CHECK_EN defined: the block checks beats 1–7 against the op and addr captured on beat 0.
  - On a mismatch, the entry's error bit is set and proto_err goes to 1 the next cycle.
  - proto_err holds until rst.
  - Assembly and beat counting proceed unchanged.
- L2RESP_CHECK_EN undefined: there is no comparison logic, and proto_err=0 constantly.

## Structure
- Shared package l2_pkg holds:
  - op encodings (OP_RD etc.), shared with the L2 data store;
  - L2_BEATS=8 and L2_BEAT_W=64;
  - the line address width type (addr [31:6]);
  - the line data type (512-bit).
- One natural sub-module, l2resp_linebuf: the two-entry line storage with per-word write enables and a read mux on rp. Pointer/count control stays in l2resp_asm.

## Test plan
- Single line:
  - Stimulus: 8 back-to-back beats, addr=0x0000123, rdata=0x1111_0000_0000_000n for beat n, line_ready=1.
  - Response: line_valid for exactly 1 cycle, one cycle after beat 7; word n = beat n data; line_error=0.
- Backpressure:
  - Stimulus: 3 lines, line_ready=0.
  - Response: resp_ready drops the cycle after the 2nd line's beat 7. The 3rd line is stalled at beat 0. Raising line_ready for one cycle restores resp_ready the next cycle, and lines arrive in order.
- Error:
  - Stimulus: l2_resp_error=1 on beat 3 of line A only.
  - Response: line A has line_error=1; the following line B has line_error=0.
- Simultaneous completion and pop:
  - Stimulus: cnt=1, beat 7 of the next line and line_ready=1 in the same cycle.
  - Response: cnt stays 1 and the new line appears at the head the next cycle.
- Reset mid-burst:
  - Stimulus: rst for 1 cycle after beat 4, then a fresh 8-beat line.
  - Response: only the fresh line is output, with correct words.
- Checker (L2RESP_CHECK_EN):
  - Stimulus: addr changes on beat 5.
  - Response: line_error=1 for that line, proto_err=1 from the next cycle and held until rst.
